// File: rtl/y_rmw_pkg.sv
// Shared types and helpers for the Y-matrix read-modify-write writer.
package y_rmw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_LANES  = 4;
    localparam int DEF_LANE_W = 64;
    localparam int DEF_VAL_W  = 48;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_RD_LAT = 1;

    // Widest lane the merge helper supports; narrower lanes are zero-extended.
    localparam int MAX_LANE_W = 128;
    typedef logic [MAX_LANE_W-1:0] lane_t;

    // Replace (acc=0) or complex-add (acc=1) the value field of one lane.
    // Each half wraps on its own; pad bits above val_w pass through.
    function automatic lane_t lane_merge(input lane_t old_lane, input lane_t val,
                                         input int val_w, input logic acc);
        lane_t one;
        lane_t half_m;
        lane_t val_m;
        lane_t new_v;
        one    = lane_t'(1);
        half_m = (one << (val_w >> 1)) - one;
        val_m  = (half_m << (val_w >> 1)) | half_m;
        if (acc) begin
            new_v = ((((old_lane >> (val_w >> 1)) + (val >> (val_w >> 1))) & half_m) << (val_w >> 1))
                  | ((old_lane + val) & half_m);
        end else begin
            new_v = val & val_m;
        end
        return (old_lane & ~val_m) | new_v;
    endfunction

endpackage

// File: rtl/y_rmw_fifo.sv
// Count-based synchronous FIFO holding queued Y updates; head is shown combinationally.
module y_rmw_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/y_rmw_writer.sv
// Queued read-modify-write engine committing lane updates into the row-organised Y memory.
// Optional accumulate mode (in_acc port, complex add) is enabled by defining Y_RMW_ACCUM_EN.
module y_rmw_writer
    import y_rmw_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LANES  = DEF_LANES,
    parameter int LANE_W = DEF_LANE_W,
    parameter int VAL_W  = DEF_VAL_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [LANES-1:0]         in_lane_oh,
    input  logic [VAL_W-1:0]         in_data,
    input  logic                     in_last,
`ifdef Y_RMW_ACCUM_EN
    input  logic                     in_acc,
`endif
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [LANES*LANE_W-1:0]  rd_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [LANES*LANE_W-1:0]  wr_data,
    output logic                     busy,
    output logic                     done
);
    localparam int ROW_W = LANES * LANE_W;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int WC_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
`ifdef Y_RMW_ACCUM_EN
    localparam int ACC_W = 1;
`else
    localparam int ACC_W = 0;
`endif
    localparam int ENTRY_W = ADDR_W + LANES + VAL_W + 1 + ACC_W;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_cnt;
    logic [ENTRY_W-1:0] push_entry, head;
    logic [ADDR_W-1:0]  head_addr;
    logic [LANES-1:0]   head_mask;
    logic [VAL_W-1:0]   head_val;
    logic               head_last, head_acc;

    assign in_ready  = !reset && !fifo_full;
    assign fifo_push = in_valid && in_ready;

`ifdef Y_RMW_ACCUM_EN
    assign push_entry = {in_acc, in_last, in_data, in_lane_oh, in_addr};
    assign head_acc   = head[ENTRY_W-1];
`else
    assign push_entry = {in_last, in_data, in_lane_oh, in_addr};
    assign head_acc   = 1'b0;
`endif
    assign head_addr = head[ADDR_W-1:0];
    assign head_mask = head[ADDR_W +: LANES];
    assign head_val  = head[ADDR_W+LANES +: VAL_W];
    assign head_last = head[ADDR_W+LANES+VAL_W];

    y_rmw_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    state_e             state_q, state_d;
    logic [WC_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic               rd_en_q, rd_en_d, wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [ROW_W-1:0]   wr_data_q, wr_data_d, merged;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [LANES-1:0]   cur_mask_q, cur_mask_d;
    logic [VAL_W-1:0]   cur_val_q, cur_val_d;
    logic               cur_last_q, cur_last_d, cur_acc_q, cur_acc_d;
    logic               take_head;

    always_comb begin
        merged = rd_data;
        for (int l = 0; l < LANES; l++) begin
            if (cur_mask_q[l]) begin
                merged[l*LANE_W +: LANE_W] = LANE_W'(lane_merge(lane_t'(rd_data[l*LANE_W +: LANE_W]),
                                                                lane_t'(cur_val_q), VAL_W, cur_acc_q));
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        take_head  = 1'b0;
        fifo_pop   = 1'b0;
        cur_addr_d = cur_addr_q;
        cur_mask_d = cur_mask_q;
        cur_val_d  = cur_val_q;
        cur_last_d = cur_last_q;
        cur_acc_d  = cur_acc_q;
        case (state_q)
            ST_IDLE:  take_head = !fifo_empty;
            ST_READ: begin
                state_d    = ST_WAIT;
                wait_cnt_d = WC_W'(RD_LAT - 1);
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d   = ST_WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = cur_addr_q;
                    wr_data_d = merged;
                end else begin
                    wait_cnt_d = wait_cnt_q - WC_W'(1);
                end
            end
            ST_WRITE: begin
                done_d = cur_last_q;
                // Zero-mask heads go back through IDLE so two done pulses never merge.
                take_head = !fifo_empty && (|head_mask);
                state_d   = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
        if (take_head) begin
            fifo_pop   = 1'b1;
            cur_addr_d = head_addr;
            cur_mask_d = head_mask;
            cur_val_d  = head_val;
            cur_last_d = head_last;
            cur_acc_d  = head_acc;
            if (|head_mask) begin
                state_d   = ST_READ;
                rd_en_d   = 1'b1;
                rd_addr_d = head_addr;
            end else begin
                done_d = head_last;
            end
        end
        busy_d = (state_d != ST_IDLE) || fifo_push || (fifo_cnt > CW'(1))
               || ((fifo_cnt == CW'(1)) && !fifo_pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clock) begin
        cur_addr_q <= cur_addr_d;
        cur_mask_q <= cur_mask_d;
        cur_val_q  <= cur_val_d;
        cur_last_q <= cur_last_d;
        cur_acc_q  <= cur_acc_d;
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_y_rmw_writer.sv
// Self-checking bench for y_rmw_writer: memory model, row-level reference model and directed updates.
module tb_y_rmw_writer;
    localparam int ADDR_W = 11;
    localparam int LANES  = 4;
    localparam int LANE_W = 64;
    localparam int VAL_W  = 48;
    localparam int DEPTH  = 4;
    localparam int RD_LAT = 2;
    localparam int ROW_W  = LANES * LANE_W;
    localparam int H      = VAL_W / 2;
    localparam int NROWS  = 1 << ADDR_W;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [ADDR_W-1:0] in_addr = '0;
    logic [LANES-1:0]  in_lane_oh = '0;
    logic [VAL_W-1:0]  in_data = '0;
    logic in_last = 1'b0;
    logic tb_acc = 1'b0;
    logic rd_en, wr_en, busy, done;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [ROW_W-1:0]  rd_data, wr_data;

    y_rmw_writer #(.ADDR_W(ADDR_W), .LANES(LANES), .LANE_W(LANE_W), .VAL_W(VAL_W),
                   .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_lane_oh(in_lane_oh), .in_data(in_data), .in_last(in_last),
`ifdef Y_RMW_ACCUM_EN
        .in_acc(tb_acc),
`endif
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, exp_done = 0;
    int last_wr_cyc = 0, last_done_cyc = 0, last_acc_cyc = 0;
    int wr_cycles[$];
    logic saw_stall = 1'b0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ROW_W-1:0]  row;
        int                cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [ROW_W-1:0]  mem    [NROWS];
    logic [ROW_W-1:0]  shadow [NROWS];
    logic [ADDR_W-1:0] rpipe  [RD_LAT];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [ROW_W-1:0]  pl_data = '0;

    assign rd_data = mem[rpipe[RD_LAT-1]];

    task automatic check_row(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: what a row must look like after one update, lane by lane.
    function automatic logic [ROW_W-1:0] apply(input logic [ROW_W-1:0] row, input logic [LANES-1:0] m,
                                               input logic [VAL_W-1:0] v, input logic acc);
        logic [LANE_W-1:0] ln;
        logic [H-1:0] re, im;
        for (int l = 0; l < LANES; l++) begin
            if (m[l]) begin
                ln = row[l*LANE_W +: LANE_W];
                if (acc) begin
                    re = ln[VAL_W-1:H] + v[VAL_W-1:H];
                    im = ln[H-1:0] + v[H-1:0];
                    ln[VAL_W-1:0] = {re, im};
                end else begin
                    ln[VAL_W-1:0] = v;
                end
                row[l*LANE_W +: LANE_W] = ln;
            end
        end
        return row;
    endfunction

    // Memory, preload and model update on every accepted push.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        rpipe[0] <= rd_addr;
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
        if (wr_en) mem[wr_addr] <= wr_data;
        if (pl_en) begin
            mem[pl_addr]    <= pl_data;
            shadow[pl_addr] <= pl_data;
        end
        if (reset) begin
            for (int i = 0; i < NROWS; i++) shadow[i] <= mem[i];
            exp_q.delete();
            exp_done <= done_cnt;
        end else if (in_valid && in_ready) begin
            last_acc_cyc <= cyc;
            if (in_last) exp_done <= exp_done + 1;
            if (in_lane_oh != '0) begin
                shadow[in_addr] <= apply(shadow[in_addr], in_lane_oh, in_data, tb_acc);
                exp_q.push_back('{in_addr, apply(shadow[in_addr], in_lane_oh, in_data, tb_acc), cyc});
            end
        end
    end

    // Compare process: every memory access against the model.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (rd_en) begin
                rd_cnt++;
                if (exp_q.size() == 0) check_int("rd_unexpected", 1, 0);
                else check_int("rd_addr", int'(rd_addr), int'(exp_q[0].addr));
            end
            if (wr_en) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                wr_cycles.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check_int("wr_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_int("wr_addr", int'(wr_addr), int'(e.addr));
                    check_row("wr_data", wr_data, e.row);
                    check_int("wr_latency_min", int'(cyc >= e.cyc + RD_LAT + 3), 1);
                end
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [ROW_W-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [LANES-1:0] m,
                        input logic [VAL_W-1:0] d, input logic last, input logic acc);
        int n = 0;
        in_valid = 1'b1; in_addr = a; in_lane_oh = m; in_data = d; in_last = last; tb_acc = acc;
        while (!in_ready && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) check_int("push_timeout", 1, 0);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) check_int("idle_timeout", 1, 0);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1, "timeout");
    end

    logic [LANES-1:0] t3_mask [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111, 4'b1001};
    logic [VAL_W-1:0] t3_val  [6] = '{48'h000001_000001, 48'hABCDEF_012345, 48'h7FFFFF_800000,
                                      48'h000000_FFFFFF, 48'h555555_AAAAAA, 48'h123456_789ABC};

    initial begin
        int r0, w0, d0, p, n;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_int("rst_in_ready", int'(in_ready), 0);
        check_int("rst_rd_en", int'(rd_en), 0);
        check_int("rst_wr_en", int'(wr_en), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        check_int("rst_rd_addr", int'(rd_addr), 0);
        check_int("rst_wr_addr", int'(wr_addr), 0);
        check_row("rst_wr_data", wr_data, '0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_int("in_ready_after_rst", int'(in_ready), 1);
        @(posedge clock); #1;

        // Single overwrite into an all-ones row.
        preload(11'h005, '1);
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        push(11'h005, 4'b0010, 48'hAAAA_BBBB_CCCC, 1'b1, 1'b0);
        p = last_acc_cyc;
        wait_idle();
        check_row("t1_row", mem[11'h005], {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                           64'hFFFF_AAAA_BBBB_CCCC, 64'hFFFF_FFFF_FFFF_FFFF});
        check_int("t1_rd_count", rd_cnt - r0, 1);
        check_int("t1_wr_count", wr_cnt - w0, 1);
        check_int("t1_wr_cycle", last_wr_cyc, p + RD_LAT + 3);
        check_int("t1_done_count", done_cnt - d0, 1);
        check_int("t1_done_cycle", last_done_cyc, last_wr_cyc + 1);

        // Same-address back-to-back overwrite.
        preload(11'h010, '0);
        push(11'h010, 4'b0001, 48'h1, 1'b0, 1'b0);
        push(11'h010, 4'b0001, 48'h2, 1'b1, 1'b0);
        wait_idle();
        check_row("t2_row", mem[11'h010], {192'h0, 64'h2});
`ifdef Y_RMW_ACCUM_EN
        preload(11'h011, '0);
        push(11'h011, 4'b0001, 48'h000001_000001, 1'b0, 1'b1);
        push(11'h011, 4'b0001, 48'h000003_FFFFFF, 1'b1, 1'b1);
        wait_idle();
        check_row("t2_acc_row", mem[11'h011], {192'h0, 64'h0000_0000_0400_0000});
`endif

        // Six back-to-back updates through a four-deep queue.
        for (int i = 0; i < 6; i++) preload(ADDR_W'(11'h020 + i), '1);
        w0 = wr_cycles.size();
        saw_stall = 1'b0;
        for (int i = 0; i < 6; i++) push(ADDR_W'(11'h020 + i), t3_mask[i], t3_val[i], i == 5, 1'b0);
        wait_idle();
        check_int("t3_wr_count", wr_cycles.size() - w0, 6);
        check_int("t3_ready_stall", int'(saw_stall), 1);
        for (int i = w0 + 1; i < wr_cycles.size(); i++)
            check_int("t3_wr_spacing", wr_cycles[i] - wr_cycles[i-1], RD_LAT + 2);
        check_row("t3_last_row", mem[11'h025], {64'hFFFF_1234_5678_9ABC, 64'hFFFF_FFFF_FFFF_FFFF,
                                                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_1234_5678_9ABC});

        // Zero-mask last entry: no memory traffic, done one cycle after the pop.
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        push(11'h040, 4'b0000, 48'hDEAD, 1'b1, 1'b0);
        p = last_acc_cyc;
        wait_idle();
        check_int("t4_rd_count", rd_cnt - r0, 0);
        check_int("t4_wr_count", wr_cnt - w0, 0);
        check_int("t4_done_count", done_cnt - d0, 1);
        check_int("t4_done_cycle", last_done_cyc, p + 2);

        // Reset during WAIT discards the in-flight and queued updates.
        preload(11'h030, {4{64'h5555_5555_5555_5555}});
        w0 = wr_cnt;
        push(11'h030, 4'b0100, 48'h0F0F0F_F0F0F0, 1'b0, 1'b0);
        push(11'h031, 4'b0001, 48'h1, 1'b1, 1'b0);
        n = 0;
        @(negedge clock);
        while (!rd_en && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_int("t5_saw_read", int'(rd_en), 1);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check_int("t5_wr_en_in_reset", int'(wr_en), 0);
        check_int("t5_busy_in_reset", int'(busy), 0);
        repeat (3) begin
            @(negedge clock);
            check_int("t5_wr_en_held", int'(wr_en), 0);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check_int("t5_busy_after", int'(busy), 0);
        check_int("t5_no_write", wr_cnt - w0, 0);
        check_row("t5_row_kept", mem[11'h030], {4{64'h5555_5555_5555_5555}});
        push(11'h030, 4'b0100, 48'h0F0F0F_F0F0F0, 1'b1, 1'b0);
        wait_idle();
        check_row("t5_row_after", mem[11'h030], {64'h5555_5555_5555_5555, 64'h5555_0F0F_0FF0_F0F0,
                                                 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555});
        check_int("done_total", done_cnt, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
